// File: rtl/fir_coef_reload_if.sv
// Host/FIR-facing signal bundle for the coefficient reload controller.
// slave = controller side, master = host + FIR core side.
interface fir_coef_reload_if #(
  parameter int NUM_TAPS = 16,
  parameter int COEF_W   = 16,
  parameter int CFG_W    = 8,
  parameter int FSEL_W   = 4,
  parameter int ADDR_W   = $clog2(NUM_TAPS)
);
  logic              coef_we;
  logic [ADDR_W-1:0] coef_waddr;
  logic [COEF_W-1:0] coef_wdata;
  logic              start;
  logic [FSEL_W-1:0] fsel;
  logic              busy;
  logic              done;
  logic              wr_drop;
  logic              reload_tvalid;
  logic              reload_tready;
  logic              reload_tlast;
  logic [COEF_W-1:0] reload_tdata;
  logic              config_tvalid;
  logic              config_tready;
  logic [CFG_W-1:0]  config_tdata;

  modport slave (
    input  coef_we, coef_waddr, coef_wdata, start, fsel, reload_tready, config_tready,
    output busy, done, wr_drop, reload_tvalid, reload_tlast, reload_tdata,
           config_tvalid, config_tdata
  );

  modport master (
    output coef_we, coef_waddr, coef_wdata, start, fsel, reload_tready, config_tready,
    input  busy, done, wr_drop, reload_tvalid, reload_tlast, reload_tdata,
           config_tvalid, config_tdata
  );
endinterface

// File: rtl/fir_coef_reload_ctrl.sv
// Streams a locally held coefficient set into the FIR reload channel, then one config word.
// Optional FIR_RELOAD_CHECKSUM_EN adds a 16-bit running sum of handshaked reload beats.
module fir_coef_reload_ctrl #(
  parameter int NUM_TAPS = 16,
  parameter int COEF_W   = 16,
  parameter int CFG_W    = 8,
  parameter int FSEL_W   = 4,
  parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
  input  logic clk,
  input  logic resetn,
  fir_coef_reload_if.slave bus
`ifdef FIR_RELOAD_CHECKSUM_EN
  , output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RELOAD, S_CONFIG, S_FIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [FSEL_W-1:0] fsel_q;
  logic              busy_q, done_q, wr_drop_q;
  logic              rl_vld_q, rl_last_q;
  logic [COEF_W-1:0] rl_data_q;
  logic              cf_vld_q;
  logic [CFG_W-1:0]  cf_data_q;
  logic [COEF_W-1:0] coef_q [NUM_TAPS];

  logic              wr_ok, rl_hs, cf_hs, at_last;
  logic [ADDR_W-1:0] idx_d;
  logic [COEF_W-1:0] coef0_d;

  assign wr_ok   = bus.coef_we && ({1'b0, bus.coef_waddr} < (ADDR_W+1)'(NUM_TAPS));
  assign rl_hs   = rl_vld_q && bus.reload_tready;
  assign cf_hs   = cf_vld_q && bus.config_tready;
  assign at_last = (idx_q == ADDR_W'(NUM_TAPS-1));
  assign idx_d   = idx_q + 1'b1;
  // A write to tap 0 on the same edge as start must be what the first beat carries.
  assign coef0_d = (wr_ok && bus.coef_waddr == '0) ? bus.coef_wdata : coef_q[0];

  // Register file deliberately has no reset.
  always_ff @(posedge clk) begin
    if (wr_ok && state_q == S_IDLE) coef_q[bus.coef_waddr] <= bus.coef_wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      fsel_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      rl_vld_q  <= 1'b0;
      rl_last_q <= 1'b0;
      rl_data_q <= '0;
      cf_vld_q  <= 1'b0;
      cf_data_q <= '0;
    end else begin
      done_q    <= 1'b0;
      wr_drop_q <= wr_ok && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            fsel_q    <= bus.fsel;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            rl_vld_q  <= 1'b1;
            rl_last_q <= 1'b0;
            rl_data_q <= coef0_d;
            state_q   <= S_RELOAD;
          end
        end
        S_RELOAD: begin
          if (rl_hs) begin
            if (at_last) begin
              rl_vld_q  <= 1'b0;
              rl_last_q <= 1'b0;
              cf_vld_q  <= 1'b1;
              cf_data_q <= CFG_W'(fsel_q);
              state_q   <= S_CONFIG;
            end else begin
              idx_q     <= idx_d;
              rl_data_q <= coef_q[idx_d];
              rl_last_q <= (idx_d == ADDR_W'(NUM_TAPS-1));
            end
          end
        end
        S_CONFIG: begin
          if (cf_hs) begin
            cf_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FIR_RELOAD_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        csum_q <= '0;
    else if (state_q == S_IDLE && bus.start) csum_q <= '0;
    else if (rl_hs)                     csum_q <= csum_q + 16'(rl_data_q);
  end

  assign checksum = csum_q;
`endif

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.wr_drop       = wr_drop_q;
  assign bus.reload_tvalid = rl_vld_q;
  assign bus.reload_tlast  = rl_last_q;
  assign bus.reload_tdata  = rl_data_q;
  assign bus.config_tvalid = cf_vld_q;
  assign bus.config_tdata  = cf_data_q;

endmodule

// File: tb/tb_fir_coef_reload_ctrl.sv
// Directed bench for fir_coef_reload_ctrl; also covers the checksum when FIR_RELOAD_CHECKSUM_EN is defined.
module tb_fir_coef_reload_ctrl;
  localparam int NT = 16, CW = 16, FW = 8, SW = 4, AW = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  fir_coef_reload_if #(.NUM_TAPS(NT), .COEF_W(CW), .CFG_W(FW), .FSEL_W(SW), .ADDR_W(AW)) bus ();
`ifdef FIR_RELOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  fir_coef_reload_ctrl #(.NUM_TAPS(NT), .COEF_W(CW), .CFG_W(FW), .FSEL_W(SW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
`ifdef FIR_RELOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_c [NT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [CW-1:0] d);
    bus.coef_we = 1'b1; bus.coef_waddr = AW'(a); bus.coef_wdata = d;
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask

  // Entered and left on a negedge. n counts negedges after the start edge t, so
  // done shows up after edge t+NT+1 (the t+NT+2 cycle) at full throughput.
  task automatic do_seq(input logic [SW-1:0] fs, input bit bp, input int cfg_stall,
                        input bit inj_mid, input bit inj_fin, input bit wr0, input logic [CW-1:0] wr0_d);
    int beat, n;
    bit drop_exp, inj_done, rdy;
    bus.start = 1'b1; bus.fsel = fs;
    bus.reload_tready = 1'b1; bus.config_tready = (cfg_stall == 0);
    if (wr0) begin bus.coef_we = 1'b1; bus.coef_waddr = '0; bus.coef_wdata = wr0_d; end
    @(negedge clk);
    bus.start = 1'b0; bus.coef_we = 1'b0; bus.fsel = ~fs;
    beat = 0; n = 0; drop_exp = 0; inj_done = 0;
    while (beat < NT && n < 300) begin
      chk("rl_vld", bus.reload_tvalid, 1);
      chk("rl_data", bus.reload_tdata, exp_c[beat]);
      chk("rl_last", bus.reload_tlast, beat == NT-1);
      chk("cf_vld_in_reload", bus.config_tvalid, 0);
      chk("busy_reload", bus.busy, 1);
      chk("wr_drop", bus.wr_drop, drop_exp);
      bus.start = 1'b0; bus.coef_we = 1'b0; drop_exp = 0;
      if (inj_mid && beat == 3 && !inj_done) begin
        bus.coef_we = 1'b1; bus.coef_waddr = AW'(2); bus.coef_wdata = 16'hBEEF;
        bus.start = 1'b1; drop_exp = 1; inj_done = 1;
      end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.reload_tready = rdy;
      if (rdy) beat++;
      @(negedge clk); n++;
    end
    if (beat < NT) chk("rl_timeout", beat, NT);
    chk("wr_drop_tail", bus.wr_drop, drop_exp);
    bus.start = 1'b0; bus.coef_we = 1'b0; bus.reload_tready = 1'b1;
    for (int s = 0; s < cfg_stall; s++) begin
      chk("cf_vld_stall", bus.config_tvalid, 1);
      chk("cf_data_stall", bus.config_tdata, FW'(fs));
      chk("rl_vld_in_cfg", bus.reload_tvalid, 0);
      chk("busy_cfg", bus.busy, 1);
      bus.config_tready = 1'b0;
      @(negedge clk); n++;
    end
    chk("cf_vld", bus.config_tvalid, 1);
    chk("cf_data", bus.config_tdata, FW'(fs));
    chk("rl_vld_in_cfg", bus.reload_tvalid, 0);
    chk("rl_last_in_cfg", bus.reload_tlast, 0);
    chk("busy_cfg", bus.busy, 1);
    chk("done_early", bus.done, 0);
    bus.config_tready = 1'b1;
    @(negedge clk); n++;
    chk("done", bus.done, 1);
    chk("busy_fin", bus.busy, 0);
    chk("cf_vld_fin", bus.config_tvalid, 0);
    if (!bp && cfg_stall == 0) chk("latency", n, NT+1);
    if (inj_fin) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_single", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("rl_vld_idle", bus.reload_tvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coef_we = 0; bus.coef_waddr = '0; bus.coef_wdata = '0;
    bus.start = 0; bus.fsel = '0; bus.reload_tready = 1; bus.config_tready = 1;
    #1 resetn = 1'b0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wr_drop", bus.wr_drop, 0);
    chk("rst_rl_vld", bus.reload_tvalid, 0);
    chk("rst_rl_last", bus.reload_tlast, 0);
    chk("rst_rl_data", bus.reload_tdata, 0);
    chk("rst_cf_vld", bus.config_tvalid, 0);
    chk("rst_cf_data", bus.config_tdata, 0);
`ifdef FIR_RELOAD_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NT; i++) begin
      wr(i, 16'h0100 + 16'(i));
      exp_c[i] = 16'h0100 + 16'(i);
    end

    // full throughput, fsel=3
    do_seq(4'd3, 0, 0, 0, 0, 0, '0);
    // random reload backpressure, config stalled 5 cycles
    do_seq(4'd5, 1, 5, 0, 0, 0, '0);
    // dropped write + ignored start mid-reload, start during FIN ignored
    do_seq(4'd3, 0, 0, 1, 1, 0, '0);
    // start the cycle after FIN: accepted, coef[2] still old
    do_seq(4'd9, 0, 0, 0, 0, 0, '0);
    wr(2, 16'hBEEF);
    exp_c[2] = 16'hBEEF;
    do_seq(4'd3, 0, 0, 0, 0, 0, '0);
    // write to tap 0 on the same edge as start
    exp_c[0] = 16'h0ABC;
    do_seq(4'd15, 0, 0, 0, 0, 1, 16'h0ABC);

    // async reset after beat 7 handshake
    bus.start = 1'b1; bus.fsel = 4'd6; bus.reload_tready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("pre_rst_data", bus.reload_tdata, exp_c[k]);
      @(negedge clk);
    end
    chk("pre_rst_beat8", bus.reload_tdata, exp_c[8]);
    resetn = 1'b0;
    #1;
    chk("arst_rl_vld", bus.reload_tvalid, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_cf_vld", bus.config_tvalid, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_seq(4'd6, 0, 0, 0, 0, 0, '0);

`ifdef FIR_RELOAD_CHECKSUM_EN
    for (int i = 0; i < NT; i++) begin wr(i, 16'h1000); exp_c[i] = 16'h1000; end
    do_seq(4'd1, 0, 0, 0, 0, 0, '0);
    chk("checksum_wrap", checksum, 16'h0000);
    for (int i = 0; i < NT; i++) begin wr(i, 16'(i + 1)); exp_c[i] = 16'(i + 1); end
    do_seq(4'd2, 1, 2, 0, 0, 0, '0);
    chk("checksum_sum", checksum, 16'h0088);
    repeat (3) @(negedge clk);
    chk("checksum_hold", checksum, 16'h0088);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
